// File: rtl/abro_input_cond_if.sv
// rtl/abro_input_cond_if.sv - raw inputs and conditioned event outputs of the ABRO input stage
//
// Purpose: bundles the raw asynchronous A/B/R levels and the tick-aligned
// event pulses that the conditioning stage hands to the ABRO controller.
// Signals:
//   A_raw, B_raw, R_raw : raw asynchronous input levels (driven by master)
//   A, B, R             : single-cycle event pulses aligned with tick (driven by slave)
//   tick                : reaction-instant strobe (driven by slave)
// Modports:
//   master : environment side, drives raw levels and observes events
//   slave  : conditioning stage side

interface abro_input_cond_if;
   logic A_raw;
   logic B_raw;
   logic R_raw;
   logic A;
   logic B;
   logic R;
   logic tick;

   modport master (
      output A_raw, B_raw, R_raw,
      input  A, B, R, tick
   );

   modport slave (
      input  A_raw, B_raw, R_raw,
      output A, B, R, tick
   );
endinterface

// File: rtl/abro_input_cond.sv
// rtl/abro_input_cond.sv - synchronize, debounce and tick-align the A/B/R inputs of the ABRO controller
//
// Purpose: three independent lanes (A, B, R), each with a 2-FF synchronizer,
// a debouncer producing a clean level, and a pending flag that holds a rising
// edge until the next reaction tick. A shared counter produces the tick every
// TICK_PERIOD cycles; at a tick every lane reports pending-or-new rises as a
// one-cycle pulse, so each occurrence lands in exactly one reaction.
// Parameters:
//   DB_LEN      : cycles s2 must differ from lvl before lvl follows (>=1)
//   TICK_PERIOD : clock cycles per reaction tick (>=1)
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   io  : abro_input_cond_if.slave (A_raw/B_raw/R_raw in, A/B/R/tick out)
// Build option:
//   ABRO_COND_DEBOUNCE_EN defined   -> debounce counters built, DB_LEN honoured
//   ABRO_COND_DEBOUNCE_EN undefined -> lvl follows s2 every edge (as DB_LEN=1)

module abro_input_cond #(
   parameter int DB_LEN      = 4,
   parameter int TICK_PERIOD = 8
) (
   input  logic              clk,
   input  logic              rst,
   abro_input_cond_if.slave  io
);

   localparam int            TW    = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
   localparam logic [TW-1:0] TLAST = TW'(TICK_PERIOD - 1);

   if (DB_LEN < 1 || TICK_PERIOD < 1) begin : g_bad_param
      $error("abro_input_cond: DB_LEN and TICK_PERIOD must both be >= 1");
   end

   // Lane bit order everywhere: [0]=A, [1]=B, [2]=R
   logic [2:0]    w_raw;
   logic [2:0]    r_s1;
   logic [2:0]    r_s2;
   logic [2:0]    r_lvl;
   logic [2:0]    w_lvl_nxt;
   logic [2:0]    w_rise;
   logic [2:0]    r_pend;
   logic [2:0]    r_out;
   logic [TW-1:0] r_tcnt;
   logic          r_tick;
   logic          w_tick_edge;

   assign w_raw       = {io.R_raw, io.B_raw, io.A_raw};
   assign w_tick_edge = (r_tcnt == TLAST);

   // Two-stage synchronizer for the asynchronous raw levels
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= w_raw;
         r_s2 <= r_s1;
      end
   end

`ifdef ABRO_COND_DEBOUNCE_EN
   localparam int            CW    = $clog2(DB_LEN) + 1;
   localparam logic [CW-1:0] CLAST = CW'(DB_LEN - 1);

   logic [CW-1:0] r_dcnt [3];

   // lvl takes the new value on the DB_LEN-th consecutive mismatching sample
   always_comb begin
      w_lvl_nxt = r_lvl;
      for (int i = 0; i < 3; i++) begin
         if ((r_s2[i] != r_lvl[i]) && (r_dcnt[i] == CLAST)) begin
            w_lvl_nxt[i] = r_s2[i];
         end
      end
   end

   // Counter restarts whenever s2 agrees with lvl and after every lvl update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            r_dcnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if ((r_s2[i] == r_lvl[i]) || (r_dcnt[i] == CLAST)) begin
               r_dcnt[i] <= '0;
            end else begin
               r_dcnt[i] <= r_dcnt[i] + 1'b1;
            end
         end
      end
   end
`else
   assign w_lvl_nxt = r_s2;
`endif

   // Only 0->1 updates of the debounced level are events
   assign w_rise = w_lvl_nxt & ~r_lvl;

   // A rise on the tick edge itself goes straight to the output and never
   // enters pend, so it cannot be reported twice.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lvl  <= '0;
         r_pend <= '0;
         r_out  <= '0;
         r_tcnt <= '0;
         r_tick <= 1'b0;
      end else begin
         r_lvl  <= w_lvl_nxt;
         r_tcnt <= w_tick_edge ? '0 : r_tcnt + 1'b1;
         r_tick <= w_tick_edge;
         if (w_tick_edge) begin
            r_out  <= r_pend | w_rise;
            r_pend <= '0;
         end else begin
            r_out  <= '0;
            r_pend <= r_pend | w_rise;
         end
      end
   end

   assign io.A    = r_out[0];
   assign io.B    = r_out[1];
   assign io.R    = r_out[2];
   assign io.tick = r_tick;

endmodule

// File: tb/tb_abro_input_cond.sv
// tb/tb_abro_input_cond.sv - self-checking bench for abro_input_cond with a behavioural event model

module tb_abro_input_cond;

   localparam int DB_LEN = 4;
   localparam int TP     = 20;
`ifdef ABRO_COND_DEBOUNCE_EN
   localparam int DBL = DB_LEN;
`else
   localparam int DBL = 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] raw = 3'b000;

   abro_input_cond_if io ();

   assign io.A_raw = raw[0];
   assign io.B_raw = raw[1];
   assign io.R_raw = raw[2];

   abro_input_cond #(
      .DB_LEN      (DB_LEN),
      .TICK_PERIOD (TP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Observation and model state, edge_n counts edges since reset release
   int         edge_n = 0;
   int         ticks = 0;
   int         first_tick = 0;
   int         pulses [3];
   int         last_pulse [3];
   logic [2:0] samp_q [$];
   logic       m_lvl [3];
   int         m_run [3];
   logic       m_seen [3];
   logic       m_tick;
   logic       m_rise;
   logic       m_s2;
   logic       m_exp;
   logic [2:0] dout;
   string      lane_name [3] = '{"A", "B", "R"};

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
   endtask

   // Behavioural model: s2 is the raw sample from two edges back; lvl flips
   // after DBL consecutive edges of s2 disagreeing with it; ticks fall on
   // every multiple of TP edges; a rise is reported at the first tick at or
   // after it, and rises between ticks merge into one pulse.
   always @(posedge clk) begin
      #1;
      dout = {io.R, io.B, io.A};
      if (rst) begin
         edge_n     = 0;
         ticks      = 0;
         first_tick = 0;
         samp_q.delete();
         for (int l = 0; l < 3; l++) begin
            m_lvl[l]      = 1'b0;
            m_run[l]      = 0;
            m_seen[l]     = 1'b0;
            pulses[l]     = 0;
            last_pulse[l] = 0;
         end
         check("rst_outputs", int'({dout, io.tick}), 0);
      end else begin
         edge_n++;
         m_tick = ((edge_n % TP) == 0);
         check("tick", int'(io.tick), int'(m_tick));
         if (io.tick) begin
            ticks++;
            if (first_tick == 0) first_tick = edge_n;
         end
         for (int l = 0; l < 3; l++) begin
            m_s2   = (samp_q.size() >= 2) ? samp_q[samp_q.size() - 2][l] : 1'b0;
            m_rise = 1'b0;
            if (m_s2 != m_lvl[l]) begin
               m_run[l]++;
               if (m_run[l] == DBL) begin
                  m_lvl[l] = m_s2;
                  m_run[l] = 0;
                  m_rise   = m_s2;
               end
            end else begin
               m_run[l] = 0;
            end
            m_exp     = m_tick ? (m_seen[l] | m_rise) : 1'b0;
            m_seen[l] = m_tick ? 1'b0 : (m_seen[l] | m_rise);
            check(lane_name[l], int'(dout[l]), int'(m_exp));
            if (dout[l]) begin
               pulses[l]++;
               last_pulse[l] = edge_n;
            end
         end
         samp_q.push_back(raw);
         if (samp_q.size() > 2) void'(samp_q.pop_front());
      end
   end

   task automatic wait_edge(input int k);
      int guard = 0;
      while (edge_n < k) begin
         @(negedge clk);
         guard++;
         if (guard > 20000) begin
            $display("FAIL wait_edge: got edge %0d, expected edge %0d", edge_n, k);
            $fatal(1, "bench stalled");
         end
      end
   endtask

   task automatic do_reset(input logic [2:0] hold);
      @(negedge clk);
      rst = 1'b1;
      raw = hold;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   int hold_cnt [3];
   int k5;

   initial begin
      // Idle after reset: ticks only, on multiples of TP
      do_reset(3'b000);
      wait_edge(3 * TP);
      check("idle_ticks", ticks, 3);
      check("idle_first_tick", first_tick, TP);
      check("idle_pulses", pulses[0] + pulses[1] + pulses[2], 0);

      // A held high from before edge 1: one pulse at the first tick
      do_reset(3'b000);
      raw[0] = 1'b1;
      wait_edge(3 * TP);
      check("a_hold_count", pulses[0], 1);
      check("a_hold_edge", last_pulse[0], TP);
      raw = 3'b000;

      // B high for 3 samples: filtered unless debounce is off
      do_reset(3'b000);
      wait_edge(1);
      raw[1] = 1'b1;
      wait_edge(4);
      raw[1] = 1'b0;
      wait_edge(2 * TP);
      check("b_glitch_count", pulses[1], (DBL > 3) ? 0 : 1);
      check("b_glitch_edge", last_pulse[1], (DBL > 3) ? 0 : TP);

      // Three debounced A rises between ticks TP and 2*TP collapse to one pulse
      do_reset(3'b000);
      wait_edge(18);
      for (int j = 0; j < 3; j++) begin
         raw[0] = 1'b1;
         wait_edge(18 + 2 * DBL * j + DBL);
         raw[0] = 1'b0;
         wait_edge(18 + 2 * DBL * (j + 1));
      end
      wait_edge(3 * TP);
      check("a_multi_count", pulses[0], 1);
      check("a_multi_edge", last_pulse[0], 2 * TP);

      // A and R levels update exactly on the tick edge: reported once, there
      do_reset(3'b000);
      k5 = 19 - DBL;
      wait_edge(k5 - 1);
      raw[0] = 1'b1;
      raw[2] = 1'b1;
      wait_edge(3 * TP);
      check("ar_tick_a_count", pulses[0], 1);
      check("ar_tick_r_count", pulses[2], 1);
      check("ar_tick_a_edge", last_pulse[0], TP);
      check("ar_tick_r_edge", last_pulse[2], TP);
      check("ar_tick_b_count", pulses[1], 0);
      raw = 3'b000;

      // Reset two cycles before the tick discards the pending A
      do_reset(3'b000);
      raw[0] = 1'b1;
      wait_edge(TP - 2);
      check("rst_pend_before", pulses[0], 0);
      rst = 1'b1;
      raw = 3'b000;
      #1;
      check("rst_async_out", int'({io.R, io.B, io.A, io.tick}), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wait_edge(2 * TP);
      check("rst_pend_count", pulses[0], 0);
      check("rst_first_tick", first_tick, TP);
      check("rst_ticks", ticks, 2);

      // B held high through reset release is a fresh rise
      do_reset(3'b010);
      wait_edge(2 * TP);
      check("b_thru_rst_count", pulses[1], 1);
      check("b_thru_rst_edge", last_pulse[1], TP);

      // Randomized levels and occasional resets, checked every cycle by the model
      do_reset(3'b000);
      for (int l = 0; l < 3; l++) hold_cnt[l] = 0;
      repeat (4000) begin
         @(negedge clk);
         for (int l = 0; l < 3; l++) begin
            if (hold_cnt[l] == 0) begin
               raw[l]      = 1'($urandom_range(1, 0));
               hold_cnt[l] = int'($urandom_range(2 * DBL + 2, 1));
            end else begin
               hold_cnt[l]--;
            end
         end
         if ($urandom_range(999, 0) == 0) begin
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
